// File: rtl/issue_unit.sv
// rtl/issue_unit.sv - issue scheduler arbitrating four issue queues onto one CDB
//
// Purpose: each cycle grants read enables to ready issue-queue heads so that at
// most one result reaches the common data bus per cycle, and the non-pipelined
// divider never holds two operations at once.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   iq_{int,ls,mul,div}_rdy         queue head ready
//   cdb_flush                       misprediction flush, suppresses all grants
//   iu_{int,ls,mul,div}_r_en        combinational grants (queue pops at next edge)
//   iu_div_busy                     divider still working on an earlier divide
//   iu_cdb_res[k-1]                 CDB already claimed k cycles from now

module issue_unit #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 7,
  parameter int RES_W   = DIV_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iq_int_rdy,
  input  logic             iq_ls_rdy,
  input  logic             iq_mul_rdy,
  input  logic             iq_div_rdy,
  input  logic             cdb_flush,
  output logic             iu_int_r_en,
  output logic             iu_ls_r_en,
  output logic             iu_mul_r_en,
  output logic             iu_div_r_en,
  output logic             iu_div_busy,
  output logic [RES_W-1:0] iu_cdb_res
);

  localparam int CNT_W = $clog2(DIV_LAT);

  // res[k] = CDB slot k cycles from now is already claimed.
  logic [RES_W:1]   res, res_n;
  logic [CNT_W-1:0] div_cnt, div_cnt_n;
  logic             lru, lru_n;

  logic issue_en;
  logic int_ok, ls_ok, mul_ok, div_ok;
  logic gnt_int, gnt_ls, gnt_mul, gnt_div;

  always_comb begin
    issue_en = !reset && !cdb_flush;

    int_ok = issue_en && iq_int_rdy && !res[1];
    ls_ok  = issue_en && iq_ls_rdy  && !res[1];
    mul_ok = issue_en && iq_mul_rdy && !res[MUL_LAT];
    div_ok = issue_en && iq_div_rdy && !res[DIV_LAT] && (div_cnt == '0);

    // int and ls share the latency-1 slot; lru breaks the tie.
    gnt_int = int_ok && (!ls_ok || !lru);
    gnt_ls  = ls_ok  && (!int_ok || lru);
    gnt_mul = mul_ok;
    gnt_div = div_ok;

    // A grant now lands L cycles away; after the shift that slot is L-1 away.
    // Latency-1 results land on the very next cycle and need no reservation.
    res_n = {1'b0, res[RES_W:2]};
    if (gnt_mul) res_n[MUL_LAT-1] = 1'b1;
    if (gnt_div) res_n[DIV_LAT-1] = 1'b1;

    div_cnt_n = div_cnt;
    if (gnt_div)               div_cnt_n = CNT_W'(DIV_LAT - 1);
    else if (div_cnt != '0)    div_cnt_n = div_cnt - 1'b1;

    lru_n = lru;
    if (gnt_int)     lru_n = 1'b1;
    else if (gnt_ls) lru_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res     <= '0;
      div_cnt <= '0;
      lru     <= 1'b0;
    end else begin
      res     <= res_n;
      div_cnt <= div_cnt_n;
      lru     <= lru_n;
    end
  end

  assign iu_int_r_en = gnt_int;
  assign iu_ls_r_en  = gnt_ls;
  assign iu_mul_r_en = gnt_mul;
  assign iu_div_r_en = gnt_div;
  assign iu_div_busy = !reset && (div_cnt != '0);
  assign iu_cdb_res  = reset ? '0 : res;

endmodule

// File: tb/tb_issue_unit.sv
// tb/tb_issue_unit.sv - scoreboard bench for issue_unit against a CDB calendar model

module tb_issue_unit;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 7;
  localparam int RES_W   = DIV_LAT;
  localparam int CAL_N   = 4096;

  logic clk = 1'b0;
  logic reset, cdb_flush;
  logic iq_int_rdy, iq_ls_rdy, iq_mul_rdy, iq_div_rdy;
  logic iu_int_r_en, iu_ls_r_en, iu_mul_r_en, iu_div_r_en, iu_div_busy;
  logic [RES_W-1:0] iu_cdb_res;

  always #5 clk = ~clk;

  issue_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .iq_int_rdy (iq_int_rdy),
    .iq_ls_rdy  (iq_ls_rdy),
    .iq_mul_rdy (iq_mul_rdy),
    .iq_div_rdy (iq_div_rdy),
    .cdb_flush  (cdb_flush),
    .iu_int_r_en(iu_int_r_en),
    .iu_ls_r_en (iu_ls_r_en),
    .iu_mul_r_en(iu_mul_r_en),
    .iu_div_r_en(iu_div_r_en),
    .iu_div_busy(iu_div_busy),
    .iu_cdb_res (iu_cdb_res)
  );

  typedef struct {
    int         cyc;
    logic       g_int, g_ls, g_mul, g_div, busy;
    logic [RES_W-1:0] res;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: absolute-time CDB calendar, next cycle the divider is free,
  // and the int/ls fairness bit.
  bit cal [0:CAL_N-1];
  int cyc      = 0;
  int div_free = 0;
  bit lru_m    = 1'b0;

  task automatic step(input bit r, input bit fl, input bit ri, input bit rl,
                      input bit rm, input bit rd);
    exp_t e;
    bit ok_i, ok_l;
    @(posedge clk);
    #1;
    reset = r; cdb_flush = fl;
    iq_int_rdy = ri; iq_ls_rdy = rl; iq_mul_rdy = rm; iq_div_rdy = rd;
    e.cyc = cyc;
    e.g_int = 0; e.g_ls = 0; e.g_mul = 0; e.g_div = 0; e.busy = 0; e.res = '0;
    if (r) begin
      for (int k = cyc + 1; k < CAL_N; k++) cal[k] = 1'b0;
      div_free = cyc + 1;
      lru_m = 1'b0;
    end else begin
      for (int k = 1; k <= RES_W; k++) e.res[k-1] = cal[cyc + k];
      e.busy = (cyc < div_free);
      if (!fl) begin
        e.g_div = rd && (cyc >= div_free) && !cal[cyc + DIV_LAT];
        e.g_mul = rm && !cal[cyc + MUL_LAT];
        ok_i = ri && !cal[cyc + 1];
        ok_l = rl && !cal[cyc + 1];
        if (ok_i && ok_l) begin
          e.g_int = !lru_m;
          e.g_ls  = lru_m;
        end else begin
          e.g_int = ok_i;
          e.g_ls  = ok_l;
        end
        if (e.g_div) begin
          cal[cyc + DIV_LAT] = 1'b1;
          div_free = cyc + DIV_LAT;
        end
        if (e.g_mul) cal[cyc + MUL_LAT] = 1'b1;
        if (e.g_int || e.g_ls) cal[cyc + 1] = 1'b1;
        if (e.g_int) lru_m = 1'b1;
        if (e.g_ls)  lru_m = 1'b0;
      end
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic chk(input string name, input int c, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, act, want);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents one response.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("int_r_en", e.cyc, int'(iu_int_r_en), int'(e.g_int));
      chk("ls_r_en",  e.cyc, int'(iu_ls_r_en),  int'(e.g_ls));
      chk("mul_r_en", e.cyc, int'(iu_mul_r_en), int'(e.g_mul));
      chk("div_r_en", e.cyc, int'(iu_div_r_en), int'(e.g_div));
      chk("div_busy", e.cyc, int'(iu_div_busy), int'(e.busy));
      chk("cdb_res",  e.cyc, int'(iu_cdb_res),  int'(e.res));
    end
  end

  initial begin
    int wait_cnt;
    reset = 1; cdb_flush = 0;
    iq_int_rdy = 0; iq_ls_rdy = 0; iq_mul_rdy = 0; iq_div_rdy = 0;

    // reset, then everything ready in one cycle, then idle through divide
    step(1, 0, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 1);
    repeat (8) step(0, 0, 0, 0, 0, 0);

    // int and ls contending
    repeat (6) step(0, 0, 1, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    // mul at t, int becomes ready at t+3
    step(0, 0, 0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);

    // back-to-back divides
    repeat (16) step(0, 0, 0, 0, 0, 1);

    // flush with all ready
    repeat (3) step(0, 0, 1, 1, 1, 1);
    step(0, 1, 1, 1, 1, 1);
    repeat (3) step(0, 0, 1, 1, 1, 1);
    repeat (8) step(0, 0, 0, 0, 0, 0);

    // reset two cycles after a divide grant
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    end
    step(0, 0, 0, 0, 0, 0);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
